// File: rtl/sram_mem_controller.sv
// MEM-stage data-memory controller: 32-bit word accesses split into two
// 16-bit async SRAM phases. Optional macro: SRAM_ADDR_CHECK_EN (adds err).
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned SRAM_AW     = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
`ifdef SRAM_ADDR_CHECK_EN
  output logic               sram_ce_n,
  output logic               err
`else
  output logic               sram_ce_n
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               wr_q, wr_d;
  logic [15:0]        lo_q, lo_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               bad_q, bad_d;

  logic        req;
  logic        last;
  logic        in_phase;
  logic        chk_ok;
  logic [31:0] diff;
  logic        unused_diff;

  assign req  = mem_read | mem_write;
  assign last = (cnt_q == 4'(WAIT_CYCLES - 1));
  assign diff = address - BASE_ADDR;
  assign unused_diff = ^{diff[31:SRAM_AW+1], diff[1:0]};
  assign in_phase = (state_q == S_LOW) | (state_q == S_HIGH);
  assign chk_ok = ~bad_q;
  assign rdata = rdata_q;

  // State, phase counter and latched transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      bad_q   <= bad_d;
    end
  end

  // Next state: each half-word phase lasts WAIT_CYCLES cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req) state_d = S_LOW;
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request capture in IDLE and read-data assembly at phase ends
  always_comb begin
    base_d  = base_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    bad_d   = bad_q;
    if (state_q == S_IDLE && req) begin
      base_d  = {diff[SRAM_AW:2], 1'b0};
      wdata_d = wdata;
      wr_d    = mem_write & ~mem_read;
`ifdef SRAM_ADDR_CHECK_EN
      bad_d   = (address < BASE_ADDR) | (address[1:0] != 2'b00);
`else
      bad_d   = 1'b0;
`endif
    end
    if (state_q == S_LOW && last && !wr_q) begin
      lo_d = sram_dq_in;
    end
    if (state_q == S_HIGH && last) begin
      if (bad_q) begin
        rdata_d = 32'hDEAD_BEEF;
      end else if (!wr_q) begin
        rdata_d = {sram_dq_in, lo_q};
      end
    end
  end

  // SRAM strobes, bus and handshake outputs
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_ce_n   = 1'b1;
    ready       = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);
    if (in_phase && chk_ok) begin
      sram_ce_n = 1'b0;
      sram_addr = (state_q == S_HIGH) ? (base_q | SRAM_AW'(1)) : base_q;
      if (wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
        sram_we_n   = last & (WAIT_CYCLES != 1);
      end
    end
  end

`ifdef SRAM_ADDR_CHECK_EN
  assign err = (state_q == S_DONE) & bad_q;
`endif

endmodule
